// File: rtl/subr8s_serial.sv
// Bit-serial signed 8-bit subtractor: D = A - B, LSB-first over 9 cycles,
// with a lockstep D + B adder that flags any bit that fails to reproduce A.
module subr8s_serial #(
  parameter bit CHECK_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:0] d,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t     state, state_nxt;
  logic [8:0] a_sh, b_sh;
  logic [3:0] cnt;
  logic       cs, cc;
  logic       err_acc;
  logic       accept;
  logic       abit, bbit, diff_bit, chk_dbit, rec_bit;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (cnt == 4'd8) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign accept   = in_ready & in_valid;
  assign abit     = a_sh[0];
  assign bbit     = b_sh[0];
  assign diff_bit = abit ^ ~bbit ^ cs;
  // The check path taps the difference bit through its own net so it can be corrupted independently.
  assign chk_dbit = diff_bit;
  assign rec_bit  = chk_dbit ^ bbit ^ cc;

  // NOTE: the operand shifters are reset along with the rest; they are a few flops, not a memory array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      d       <= '0;
      cnt     <= '0;
      cs      <= 1'b0;
      cc      <= 1'b0;
      err_acc <= 1'b0;
    end else if (accept) begin
      a_sh    <= {a[7], a};
      b_sh    <= {b[7], b};
      cs      <= 1'b1;
      cc      <= 1'b0;
      cnt     <= '0;
      err_acc <= 1'b0;
    end else if (state == SHIFT) begin
      a_sh <= {1'b0, a_sh[8:1]};
      b_sh <= {1'b0, b_sh[8:1]};
      d    <= {diff_bit, d[8:1]};
      cs   <= maj(abit, ~bbit, cs);
      cc   <= maj(chk_dbit, bbit, cc);
      if (CHECK_EN && (rec_bit != abit)) err_acc <= 1'b1;
      if (cnt != 4'd8) cnt <= cnt + 4'd1;
    end
  end

  assign err = err_acc;

endmodule

// File: tb/tb_subr8s_serial.sv
// Self-checking bench for subr8s_serial: directed corner cases plus random
// operands against an arithmetic reference, on checked and unchecked builds.
module tb_subr8s_serial;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       in_ready, out_valid, err;
  logic       in_ready_nc, out_valid_nc, err_nc;
  logic [8:0] d, d_nc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  subr8s_serial #(.CHECK_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .err(err)
  );

  subr8s_serial #(.CHECK_EN(1'b0)) dut_nc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_nc),
    .a(a), .b(b), .out_valid(out_valid_nc), .out_ready(out_ready),
    .d(d_nc), .err(err_nc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: exact signed difference, truncated to the 9-bit result.
  function automatic logic [8:0] ref_diff(input logic [7:0] x, input logic [7:0] y);
    int r;
    r = int'($signed(x)) - int'($signed(y));
    return r[8:0];
  endfunction

  // One full transaction: accept, latency, result, back-pressure hold, release.
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input int hold,
                       input logic exp_err, input logic exp_err_nc);
    logic [8:0] exp_d;
    int lat;
    int bad;
    exp_d = ref_diff(av, bv);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1'b1);
    a = av; b = bv; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 30);
    check("latency", lat, 9);
    check("d", d, exp_d);
    check("err", err, exp_err);
    check("d_nc", d_nc, exp_d);
    check("err_nc", err_nc, exp_err_nc);
    check("in_ready_done", in_ready, 1'b0);
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      a = 8'($urandom); b = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || d !== exp_d || err !== exp_err) bad++;
    end
    in_valid = 1'b0;
    if (hold > 0) check("hold_stable", bad, 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("out_valid_idle", out_valid, 1'b0);
    check("in_ready_back", in_ready, 1'b1);
    check("d_persist", d, exp_d);
  endtask

  logic [7:0] pa [3];
  logic [7:0] pb [3];

  initial begin
    int idx, nres, cyc, last_cyc;
    logic acc;
    logic [8:0] exp_q [$];

    // Reset state
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_d", d, 9'h000);
    check("rst_err", err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed corner operands
    do_op(8'h64, 8'hE4, 0, 1'b0, 1'b0);
    check("d_128", d, 9'h080);
    do_op(8'h80, 8'h7F, 0, 1'b0, 1'b0);
    check("d_m255", d, 9'h101);
    do_op(8'h7F, 8'h80, 0, 1'b0, 1'b0);
    check("d_p255", d, 9'h0FF);
    do_op(8'h00, 8'h00, 20, 1'b0, 1'b0);
    check("d_zero", d, 9'h000);

    // Back-to-back with in_valid and out_ready held high
    pa[0] = 8'd5;   pb[0] = 8'd3;
    pa[1] = 8'hFF;  pb[1] = 8'd1;
    pa[2] = 8'hF9;  pb[2] = 8'hF9;
    exp_q.push_back(9'h002);
    exp_q.push_back(9'h1FE);
    exp_q.push_back(9'h000);
    idx = 0; nres = 0; cyc = 0; last_cyc = 0;
    out_ready = 1'b1;
    while (nres < 3 && cyc < 80) begin
      @(negedge clk);
      if (out_valid) begin
        check("b2b_d", d, exp_q.pop_front());
        if (nres > 0) check("b2b_spacing", cyc - last_cyc, 11);
        last_cyc = cyc;
        nres++;
      end
      if (idx < 3) begin
        a = pa[idx]; b = pb[idx]; in_valid = 1'b1; acc = in_ready;
      end else begin
        in_valid = 1'b0; acc = 1'b0;
      end
      @(posedge clk);
      if (acc) idx++;
      cyc++;
    end
    check("b2b_results", nres, 3);
    check("b2b_accepts", idx, 3);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;

    // Asynchronous reset in the middle of SHIFT
    @(negedge clk);
    a = 8'h10; b = 8'h01; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_d", d, 9'h000);
    check("mid_rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_op(8'd3, 8'd5, 0, 1'b0, 1'b0);
    check("after_rst_d", d, 9'h1FE);

    // Corrupted check-path bit: only the checking build reports it
    force dut.chk_dbit = 1'b1;
    force dut_nc.chk_dbit = 1'b1;
    do_op(8'd5, 8'd3, 0, 1'b1, 1'b0);
    release dut.chk_dbit;
    release dut_nc.chk_dbit;
    do_op(8'd5, 8'd3, 0, 1'b0, 1'b0);

    // Random operands with random back-pressure
    for (int n = 0; n < 40; n++) begin
      do_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
